// File: rtl/conv_seq_engine.sv
// conv_seq_engine: sequential multi-channel 2D convolution, one signed MAC per cycle,
// then bias, fixed-point rescale, optional ReLU and saturation into a flat result bus.
module conv_seq_engine #(
    parameter int data_width     = 8,
    parameter int frac_bits      = 0,
    parameter int input_channel  = 2,
    parameter int output_channel = 2,
    parameter int image_length   = 4,
    parameter int image_width    = 4,
    parameter int weight_length  = 2,
    parameter int weight_width   = 2,
    parameter int stride         = 1,
    parameter int padding        = 0,
    parameter int relu_en        = 1,
    localparam int result_length = (image_length - weight_length + 2 * padding) / stride + 1,
    localparam int result_width  = (image_width - weight_width + 2 * padding) / stride + 1,
    localparam int acc_width     = 2 * data_width + $clog2(input_channel * weight_length * weight_width) + 1,
    localparam int img_bits      = input_channel * image_length * image_width * data_width,
    localparam int wgt_bits      = output_channel * input_channel * weight_length * weight_width * data_width,
    localparam int bias_bits     = output_channel * data_width,
    localparam int res_bits      = output_channel * result_length * result_width * data_width
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 conv_en,
    input  logic [img_bits-1:0]  image,
    input  logic [wgt_bits-1:0]  weight,
    input  logic [bias_bits-1:0] bias,
    output logic [res_bits-1:0]  result,
    output logic                 busy,
    output logic                 out_valid
);
    localparam int cw = 16;
    localparam int img_iw = $clog2(img_bits);
    localparam int wgt_iw = $clog2(wgt_bits);
    localparam int bias_iw = $clog2(bias_bits);
    localparam int res_iw = $clog2(res_bits);
    localparam logic signed [acc_width:0] smax = {{(acc_width + 2 - data_width){1'b0}}, {(data_width - 1){1'b1}}};
    localparam logic signed [acc_width:0] smin = ~smax;

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;
    state_t state, state_nx;

    logic [cw-1:0] kc, kr, c, x, r, o;
    logic signed [acc_width-1:0] acc;
    logic last_kc, last_kr, last_c, last_x, last_r, last_o, last_tap, last_pos;
    logic signed [31:0] ir, ix;
    logic in_img;
    logic [img_iw-1:0] pix_idx;
    logic [wgt_iw-1:0] wgt_idx;
    logic [bias_iw-1:0] bias_idx;
    logic [res_iw-1:0] res_idx;
    logic [data_width-1:0] pix, wt, bv, y;
    logic signed [2*data_width-1:0] prod;
    logic signed [acc_width:0] sum, shifted, clipped;

    assign last_kc = kc == cw'(weight_width - 1);
    assign last_kr = kr == cw'(weight_length - 1);
    assign last_c = c == cw'(input_channel - 1);
    assign last_x = x == cw'(result_width - 1);
    assign last_r = r == cw'(result_length - 1);
    assign last_o = o == cw'(output_channel - 1);
    assign last_tap = last_kc && last_kr && last_c;
    assign last_pos = last_x && last_r && last_o;
    assign busy = state == MAC || state == WRITE;

    // Window taps that fall in the zero border read as 0 but still take a cycle.
    always_comb begin
        ir = $signed(32'(r)) * stride + $signed(32'(kr)) - padding;
        ix = $signed(32'(x)) * stride + $signed(32'(kc)) - padding;
        in_img = ir >= 0 && ir < image_length && ix >= 0 && ix < image_width;
        pix_idx = in_img ? img_iw'(((32'(c) * image_length + ir) * image_width + ix) * data_width) : '0;
        pix = in_img ? image[pix_idx +: data_width] : '0;
        wgt_idx = wgt_iw'((((32'(o) * input_channel + 32'(c)) * weight_length + 32'(kr)) * weight_width + 32'(kc)) * data_width);
        wt = weight[wgt_idx +: data_width];
        prod = $signed(pix) * $signed(wt);
        bias_idx = bias_iw'(32'(o) * data_width);
        bv = bias[bias_idx +: data_width];
        sum = {acc[acc_width-1], acc} + ({{(acc_width + 1 - data_width){bv[data_width-1]}}, bv} <<< frac_bits);
        shifted = sum >>> frac_bits;
        clipped = (relu_en != 0 && shifted < 0) ? '0 : shifted;
        y = clipped > smax ? smax[data_width-1:0] : clipped < smin ? smin[data_width-1:0] : clipped[data_width-1:0];
        res_idx = res_iw'(((32'(o) * result_length + 32'(r)) * result_width + 32'(x)) * data_width);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = conv_en ? MAC : IDLE;
            MAC:   state_nx = last_tap ? WRITE : MAC;
            WRITE: state_nx = last_pos ? DONE : MAC;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            kc <= '0;
            kr <= '0;
            c <= '0;
            x <= '0;
            r <= '0;
            o <= '0;
            acc <= '0;
            result <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            out_valid <= state == DONE;
            case (state)
                IDLE: if (conv_en) begin
                    result <= '0;
                    kc <= '0;
                    kr <= '0;
                    c <= '0;
                    x <= '0;
                    r <= '0;
                    o <= '0;
                    acc <= '0;
                end
                MAC: begin
                    acc <= acc + {{(acc_width - 2 * data_width){prod[2*data_width-1]}}, prod};
                    kc <= last_kc ? '0 : kc + 1'b1;
                    if (last_kc) kr <= last_kr ? '0 : kr + 1'b1;
                    if (last_kc && last_kr) c <= last_c ? '0 : c + 1'b1;
                end
                WRITE: begin
                    result[res_idx +: data_width] <= y;
                    acc <= '0;
                    x <= last_x ? '0 : x + 1'b1;
                    if (last_x) r <= last_r ? '0 : r + 1'b1;
                    if (last_x && last_r) o <= last_o ? '0 : o + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_seq_engine.sv
// tb_conv_seq_engine: scoreboard bench for conv_seq_engine across default, relu-off,
// padded/strided and fixed-point configurations.
module tb_conv_seq_engine;
    logic clk = 1'b0, reset = 1'b1;
    logic conv_en = 1'b0, en1 = 1'b0, en3 = 1'b0;
    logic [255:0] image0;
    logic [127:0] weight0;
    logic [15:0] bias0;
    logic [143:0] result0, result2;
    logic busy0, busy2, ov0, ov2;
    logic [127:0] image1;
    logic [71:0] weight1;
    logic [7:0] bias1;
    logic [31:0] result1;
    logic busy1, ov1;
    logic [7:0] image3, weight3, bias3, result3;
    logic busy3, ov3;
    int total = 0, bad = 0;
    logic [143:0] exp0_q[$], exp2_q[$];
    int small_q[$];

    always #5 clk = ~clk;

    conv_seq_engine u0 (.clk(clk), .reset(reset), .conv_en(conv_en), .image(image0), .weight(weight0),
                        .bias(bias0), .result(result0), .busy(busy0), .out_valid(ov0));
    conv_seq_engine #(.relu_en(0)) u2 (.clk(clk), .reset(reset), .conv_en(conv_en), .image(image0),
                        .weight(weight0), .bias(bias0), .result(result2), .busy(busy2), .out_valid(ov2));
    conv_seq_engine #(.input_channel(1), .output_channel(1), .weight_length(3), .weight_width(3),
                      .stride(2), .padding(1)) u1 (.clk(clk), .reset(reset), .conv_en(en1), .image(image1),
                        .weight(weight1), .bias(bias1), .result(result1), .busy(busy1), .out_valid(ov1));
    conv_seq_engine #(.frac_bits(4), .input_channel(1), .output_channel(1), .image_length(1), .image_width(1),
                      .weight_length(1), .weight_width(1)) u3 (.clk(clk), .reset(reset), .conv_en(en3),
                        .image(image3), .weight(weight3), .bias(bias3), .result(result3), .busy(busy3), .out_valid(ov3));

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [143:0] model0(input logic [255:0] img, input logic [127:0] wt,
                                            input logic [15:0] b, input bit relu);
        logic [143:0] m;
        int acc, p, w;
        m = '0;
        for (int oo = 0; oo < 2; oo++)
            for (int rr = 0; rr < 3; rr++)
                for (int xx = 0; xx < 3; xx++) begin
                    acc = 0;
                    for (int cc = 0; cc < 2; cc++)
                        for (int a = 0; a < 2; a++)
                            for (int bb = 0; bb < 2; bb++) begin
                                p = $signed(img[((cc * 4 + rr + a) * 4 + xx + bb) * 8 +: 8]);
                                w = $signed(wt[(((oo * 2 + cc) * 2 + a) * 2 + bb) * 8 +: 8]);
                                acc += p * w;
                            end
                    acc += $signed(b[oo * 8 +: 8]);
                    if (relu && acc < 0) acc = 0;
                    if (acc > 127) acc = 127;
                    if (acc < -128) acc = -128;
                    m[((oo * 3 + rr) * 3 + xx) * 8 +: 8] = 8'(acc);
                end
        return m;
    endfunction

    task automatic push_exp();
        exp0_q.push_back(model0(image0, weight0, bias0, 1'b1));
        exp2_q.push_back(model0(image0, weight0, bias0, 1'b0));
    endtask

    task automatic fill0(input int span);
        for (int i = 0; i < 32; i++) image0[i*8 +: 8] = 8'($urandom_range(0, 2 * span) - span);
        for (int i = 0; i < 16; i++) weight0[i*8 +: 8] = 8'($urandom_range(0, 2 * span) - span);
        for (int i = 0; i < 2; i++) bias0[i*8 +: 8] = 8'($urandom_range(0, 2 * span) - span);
    endtask

    task automatic pop_cmp(input string tag);
        logic [143:0] e0, e2;
        check({tag, "_sb"}, exp0_q.size(), 1);
        e0 = exp0_q.pop_front();
        e2 = exp2_q.pop_front();
        for (int i = 0; i < 18; i++) begin
            check($sformatf("%s_y%0d", tag, i), $signed(result0[i*8 +: 8]), $signed(e0[i*8 +: 8]));
            check($sformatf("%s_z%0d", tag, i), $signed(result2[i*8 +: 8]), $signed(e2[i*8 +: 8]));
        end
    endtask

    task automatic run0(input string tag, input int poke);
        int n, bc;
        push_exp();
        @(negedge clk) conv_en = 1'b1;
        @(posedge clk);
        #1 conv_en = 1'b0;
        n = 0;
        bc = 0;
        while (!ov0 && n < 400) begin
            if (busy0) bc++;
            conv_en = n == poke;
            @(posedge clk);
            #1 n++;
        end
        conv_en = 1'b0;
        check({tag, "_lat"}, n, 163);
        check({tag, "_busy"}, bc, 162);
        check({tag, "_ov2"}, ov2, 1);
        pop_cmp(tag);
        @(posedge clk);
        #1 check({tag, "_pulse"}, ov0, 0);
    endtask

    initial begin
        int n, ovs;
        image0 = {32{8'd1}};
        weight0 = {16{8'd1}};
        bias0 = '0;
        image1 = '0;
        weight1 = '0;
        bias1 = '0;
        image3 = '0;
        weight3 = '0;
        bias3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result0 == '0, 1);
        check("rst_busy", busy0, 0);
        check("rst_ov", ov0, 0);
        @(negedge clk) reset = 1'b0;

        run0("t1", -1);
        check("t1_first", $signed(result0[7:0]), 8);
        check("t1_last", $signed(result0[143:136]), 8);

        image0 = {32{8'd127}};
        weight0 = {16{8'd127}};
        bias0 = {2{8'd127}};
        run0("t3p", -1);
        check("t3p_sat", $signed(result0[7:0]), 127);
        weight0 = {16{8'h81}};
        run0("t3n", -1);
        check("t3n_relu", $signed(result0[7:0]), 0);
        check("t3n_sat", $signed(result2[7:0]), -128);

        fill0(20);
        run0("rnd1", -1);
        fill0(128);
        run0("poke", 5);

        image0 = {32{8'd1}};
        weight0 = {16{8'd1}};
        bias0 = '0;
        @(negedge clk) conv_en = 1'b1;
        @(posedge clk);
        #1 conv_en = 1'b0;
        repeat (39) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_result", result0 == '0, 1);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_ov", ov0, 0);
        @(negedge clk) reset = 1'b0;
        ovs = 0;
        repeat (200) begin
            @(posedge clk);
            #1 if (ov0 || ov2) ovs++;
        end
        check("mid_rst_no_ov", ovs, 0);
        run0("fresh", -1);

        image0 = {32{8'd2}};
        weight0 = {16{8'd1}};
        bias0 = {8'd3, 8'hFB};
        push_exp();
        @(negedge clk) conv_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 check("b2b_clear", result0 == '0, 1);
            n = 0;
            while (!ov0 && n < 400) begin
                @(posedge clk);
                #1 n++;
            end
            check("b2b_lat", n, 163);
            pop_cmp("b2b");
            if (k == 0) begin
                fill0(30);
                push_exp();
            end
        end
        @(negedge clk) conv_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("b2b_stop", busy0, 0);

        for (int i = 0; i < 16; i++) image1[i*8 +: 8] = 8'(i);
        weight1[39:32] = 8'd1;
        small_q.push_back(0);
        small_q.push_back(2);
        small_q.push_back(8);
        small_q.push_back(10);
        @(negedge clk) en1 = 1'b1;
        @(posedge clk);
        #1 en1 = 1'b0;
        n = 0;
        while (!ov1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("t2_lat", n, 41);
        for (int i = 0; i < 4; i++) check($sformatf("t2_y%0d", i), $signed(result1[i*8 +: 8]), small_q.pop_front());

        image3 = 8'h18;
        weight3 = 8'h20;
        bias3 = 8'h10;
        small_q.push_back(32'h40);
        @(negedge clk) en3 = 1'b1;
        @(posedge clk);
        #1 en3 = 1'b0;
        n = 0;
        while (!ov3 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        check("t4_lat", n, 3);
        check("t4_y", $signed(result3), small_q.pop_front());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
